meas_fifo_reader: RTL and testbench



---
 rtl/meas_fifo_reader.sv | 125 ++++++++++++
 tb/tb_meas_fifo_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/meas_fifo_reader.sv
// Drains the measurement result FIFO and serializes each word into a framed byte
// stream: sync byte, data bytes LSB first, then the XOR checksum of the data bytes.
module meas_fifo_reader #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  input  logic             fifo_n_empty_i,
  output logic             fifo_re_o,
  output logic [7:0]       m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             busy_o,
  output logic [15:0]      frame_cnt_o
);

  localparam int unsigned NB    = WIDTH / 8;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    CSUM
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             armed_q;
  logic             accept;
  logic [7:0]       data_byte;

  // Blocks the pop strobe while reset is held, so no word is lost to a held-in-reset reader.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  assign m_valid_o   = (state_q != IDLE);
  assign busy_o      = m_valid_o;
  assign accept      = m_valid_o & m_ready_i;
  assign fifo_re_o   = armed_q & (state_q == IDLE) & enable_i & fifo_n_empty_i;
  assign frame_cnt_o = frame_cnt_q;
  assign data_byte   = 8'(word_q >> {idx_q, 3'b000});

  // Stream byte decoded from registered state only; no combinational path from m_ready_i.
  always_comb begin
    m_data_o = 8'h00;
    case (state_q)
      SYNC:    m_data_o = SYNC_BYTE;
      DATA:    m_data_o = data_byte;
      CSUM:    m_data_o = csum_q;
      default: m_data_o = 8'h00;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (fifo_re_o) begin
          word_d  = fifo_data_i;
          idx_d   = '0;
          csum_d  = 8'h00;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (accept) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          csum_d = csum_q ^ data_byte;
          if (idx_q == IDX_LAST) begin
            state_d = CSUM;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      CSUM: begin
        if (accept) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= IDLE;
      word_q      <= '0;
      idx_q       <= '0;
      csum_q      <= 8'h00;
      frame_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_meas_fifo_reader.sv
// Bench for meas_fifo_reader: FIFO model plus a byte scoreboard filled when words are pushed.
module tb_meas_fifo_reader;

  localparam int NB = 4;

  logic        clk;
  logic        arstn_i;
  logic        enable_i;
  logic [31:0] fifo_data_i;
  logic        fifo_n_empty_i;
  logic        fifo_re_o;
  logic [7:0]  m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        busy_o;
  logic [15:0] frame_cnt_o;

  meas_fifo_reader #(.WIDTH(32), .SYNC_BYTE(8'hA5)) dut (
    .clk_i          (clk),
    .arstn_i        (arstn_i),
    .enable_i       (enable_i),
    .fifo_data_i    (fifo_data_i),
    .fifo_n_empty_i (fifo_n_empty_i),
    .fifo_re_o      (fifo_re_o),
    .m_data_o       (m_data_o),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (m_ready_i),
    .busy_o         (busy_o),
    .frame_cnt_o    (frame_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          pos = 0;
  int          pops = 0;
  int          done_cnt = 0;
  int          pop_cyc = 0;
  int          csum_cyc = 0;
  logic [15:0] exp_cnt = 16'h0000;
  logic        prev_stall = 1'b0;
  logic        gap_chk = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic        pop_pend;
  logic [7:0]  eb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic upd_fifo();
    fifo_n_empty_i = (fifo_q.size() != 0);
    fifo_data_i    = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  // Push a word into the FIFO model and its expected frame into the scoreboard.
  task automatic push_word(input logic [31:0] w);
    logic [7:0] cs;
    cs = 8'h00;
    fifo_q.push_back(w);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back(w[8*i +: 8]);
      cs = cs ^ w[8*i +: 8];
    end
    exp_q.push_back(cs);
    upd_fifo();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) step();
    check("frames_done", 32'(done_cnt), 32'(target));
  endtask

  // Monitor: samples at the falling edge, pops the FIFO model just after the rising edge.
  always begin
    @(negedge clk);
    cyc++;
    pop_pend = 1'b0;
    if (!arstn_i) begin
      pos        = 0;
      exp_cnt    = 16'h0000;
      prev_stall = 1'b0;
      gap_chk    = 1'b0;
      check("rst_valid", 32'(m_valid_o), 32'd0);
      check("rst_cnt", 32'(frame_cnt_o), 32'd0);
    end else begin
      check("frame_cnt", 32'(frame_cnt_o), 32'(exp_cnt));
      if (gap_chk) check("idle_gap", 32'(m_valid_o), 32'd0);
      gap_chk = 1'b0;
      if (prev_stall) begin
        check("hold_valid", 32'(m_valid_o), 32'd1);
        check("hold_data", 32'(m_data_o), 32'(prev_data));
      end
      if (fifo_re_o) begin
        check("pop_in_idle", 32'(m_valid_o), 32'd0);
        pops++;
        pop_cyc  = cyc;
        pop_pend = 1'b1;
      end
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(m_data_o), 32'hFFFF_FFFF);
        end else begin
          eb = exp_q.pop_front();
          check("byte", 32'(m_data_o), 32'(eb));
        end
        if (pos == NB + 1) begin
          pos      = 0;
          done_cnt++;
          exp_cnt  = exp_cnt + 16'd1;
          csum_cyc = cyc;
          gap_chk  = 1'b1;
        end else begin
          pos++;
        end
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
    end
    @(posedge clk);
    #1;
    if (pop_pend && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      upd_fifo();
    end
  end

  initial begin
    int p0;
    int d0;
    logic [31:0] keep[$];
    arstn_i   = 1'b0;
    enable_i  = 1'b0;
    m_ready_i = 1'b0;
    upd_fifo();
    #1;
    check("reset_valid", 32'(m_valid_o), 32'd0);
    check("reset_data", 32'(m_data_o), 32'd0);
    check("reset_re", 32'(fifo_re_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_cnt", 32'(frame_cnt_o), 32'd0);
    repeat (3) step();
    arstn_i = 1'b1;
    step();

    // Basic frame with ready held high.
    enable_i  = 1'b1;
    m_ready_i = 1'b1;
    push_word(32'h11223344);
    wait_done(1, 50);
    check("basic_pops", 32'(pops), 32'd1);
    check("basic_latency", 32'(csum_cyc - pop_cyc), 32'(NB + 2));
    check("basic_cnt", 32'(frame_cnt_o), 32'd1);

    // Backpressure: five stall cycles on the first data byte, then random ready.
    m_ready_i = 1'b0;
    push_word(32'hDEADBEEF);
    for (int i = 0; i < 20 && !m_valid_o; i++) step();
    check("bp_valid_up", 32'(m_valid_o), 32'd1);
    m_ready_i = 1'b1;
    step();
    m_ready_i = 1'b0;
    repeat (5) step();
    check("bp_stalled_data", 32'(m_data_o), 32'hEF);
    for (int i = 0; i < 200 && done_cnt < 2; i++) begin
      m_ready_i = 1'($urandom_range(0, 1));
      step();
    end
    check("bp_frames", 32'(done_cnt), 32'd2);
    check("bp_pops", 32'(pops), 32'd2);
    m_ready_i = 1'b1;

    // Enable gating.
    enable_i = 1'b0;
    p0 = pops;
    d0 = done_cnt;
    push_word(32'h0A0B0C0D);
    push_word(32'h10203040);
    push_word(32'h55AA55AA);
    repeat (20) step();
    check("gate_no_pop", 32'(pops), 32'(p0));
    check("gate_no_valid", 32'(m_valid_o), 32'd0);
    enable_i = 1'b1;
    wait_done(d0 + 1, 50);
    for (int i = 0; i < 20 && !m_valid_o; i++) step();
    check("gate_f2_started", 32'(m_valid_o), 32'd1);
    enable_i = 1'b0;
    wait_done(d0 + 2, 50);
    repeat (20) step();
    check("gate_pops", 32'(pops), 32'(p0 + 2));
    check("gate_left", 32'(fifo_q.size()), 32'd1);
    check("gate_busy", 32'(busy_o), 32'd0);
    enable_i = 1'b1;
    wait_done(d0 + 3, 50);

    // Zero word, then empty FIFO.
    push_word(32'h00000000);
    wait_done(d0 + 4, 50);
    p0 = pops;
    repeat (10) step();
    check("empty_no_pop", 32'(pops), 32'(p0));
    check("empty_re", 32'(fifo_re_o), 32'd0);
    check("empty_valid", 32'(m_valid_o), 32'd0);

    // Counter wrap via backdoor preload.
    force dut.frame_cnt_q = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    step();
    check("wrap_preload", 32'(frame_cnt_o), 32'hFFFF);
    release dut.frame_cnt_q;
    step();
    check("wrap_hold", 32'(frame_cnt_o), 32'hFFFF);
    push_word(32'hCAFEF00D);
    wait_done(d0 + 5, 50);
    check("wrap_zero", 32'(frame_cnt_o), 32'd0);

    // Reset in the middle of data byte 2.
    push_word(32'hAABBCCDD);
    push_word(32'h01020304);
    for (int i = 0; i < 50 && pos != 3; i++) step();
    check("rst_reach_idx2", 32'(pos), 32'd3);
    arstn_i = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_valid_o), 32'd0);
    check("mid_rst_data", 32'(m_data_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_re", 32'(fifo_re_o), 32'd0);
    check("mid_rst_cnt", 32'(frame_cnt_o), 32'd0);
    exp_q.delete();
    keep = fifo_q;
    fifo_q.delete();
    foreach (keep[i]) push_word(keep[i]);
    check("mid_rst_left", 32'(fifo_q.size()), 32'd1);
    step();
    step();
    arstn_i = 1'b1;
    d0 = done_cnt;
    wait_done(d0 + 1, 50);
    check("post_rst_cnt", 32'(frame_cnt_o), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
